plat_scheduler: RTL and testbench

PLAT_SCHEDULER -- requirements
Module: plat_scheduler

---
 rtl/plat_scheduler_pkg.sv | 14 +
 rtl/plat_scheduler_lfsr9.sv | 14 +
 rtl/plat_scheduler.sv | 116 +++++++++++
 tb/tb_plat_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plat_scheduler_pkg.sv
// plat_scheduler_pkg: shared constants, enums and initial platform layout
package plat_scheduler_pkg;
  localparam int NUM_PLAT = 16;
  localparam int SCREEN_H = 480;
  localparam logic [8:0] LFSR_SEED = 9'h1A5;
  typedef enum logic [1:0] {DIFF_EASY = 2'b00, DIFF_MEDIUM = 2'b01, DIFF_HARD = 2'b10} diff_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;
  function automatic logic [8:0] init_x(input int i);
    return 9'(48 + 28 * i);
  endfunction
  function automatic logic [8:0] init_y(input int i);
    return 9'(450 - 30 * i);
  endfunction
endpackage

// File: rtl/plat_scheduler_lfsr9.sv
// lfsr9: free-running 9-bit LFSR, x^9+x^5+1, reloadable with the seed
module lfsr9
  import plat_scheduler_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  output logic [8:0] q
);
  // advance every cycle; load restarts the sequence from the seed
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) q <= LFSR_SEED;
    else q <= load ? LFSR_SEED : {q[7:0], q[8] ^ q[4]};
endmodule

// File: rtl/plat_scheduler.sv
// plat_scheduler: per-frame platform scroll/respawn scan, one slot per cycle
module plat_scheduler
  import plat_scheduler_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  input  logic         game_reset,
  input  logic [7:0]   scroll_amt,
  input  logic [1:0]   difficulty,
  output logic [143:0] plat_x,
  output logic [143:0] plat_y,
  output logic [15:0]  plat_active,
  output logic         busy,
  output logic         frame_done,
  output logic [15:0]  respawn_cnt,
  output logic         overrun
);
  logic       r_meta, r_sync, r_sync_d;
  state_e     r_state;
  logic [3:0] r_idx;
  logic [7:0] r_scroll;
  logic       r_hard;
  logic [8:0] r_x [NUM_PLAT];
  logic [8:0] r_y [NUM_PLAT];
  logic [15:0] r_active;
  logic [8:0] w_lfsr;
  logic       w_edge;
  logic [9:0] w_ny;
  logic [8:0] w_wrap;
  logic       w_respawn;

  lfsr9 u_lfsr (.Clk(Clk), .Reset(Reset), .load(game_reset), .q(w_lfsr));

  assign w_edge      = r_sync & ~r_sync_d;
  assign w_ny        = {1'b0, r_y[r_idx]} + {2'b0, r_scroll};
  assign w_respawn   = w_ny >= 10'(SCREEN_H);
  assign w_wrap      = 9'(w_ny - 10'(SCREEN_H));
  assign plat_active = r_active;

  // two-flop synchroniser for frame_clk plus a delayed copy for edge detect
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) {r_meta, r_sync, r_sync_d} <= '0;
    else {r_meta, r_sync, r_sync_d} <= {frame_clk, r_meta, r_sync};

  // flatten the slot tables onto the output buses
  always_comb
    for (int i = 0; i < NUM_PLAT; i++) begin
      plat_x[9*i +: 9] = r_x[i];
      plat_y[9*i +: 9] = r_y[i];
    end

  // frame FSM: wait for an edge, scan all slots, pulse done; game_reset re-initialises
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_scroll    <= '0;
      r_hard      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      respawn_cnt <= '0;
      r_active    <= '1;
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_x[i] <= init_x(i);
        r_y[i] <= init_y(i);
      end
    end else if (game_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_scroll    <= '0;
      r_hard      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      respawn_cnt <= '0;
      r_active    <= '1;
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_x[i] <= init_x(i);
        r_y[i] <= init_y(i);
      end
    end else begin
      frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE:
          if (w_edge) begin
            r_scroll <= scroll_amt;
            r_hard   <= difficulty >= DIFF_HARD;
            r_idx    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SCAN;
          end
        S_SCAN: begin
          overrun    <= overrun | w_edge;
          r_y[r_idx] <= w_respawn ? w_wrap : w_ny[8:0];
          if (w_respawn) begin
            r_x[r_idx]      <= w_lfsr;
            r_active[r_idx] <= r_hard ? ~w_lfsr[0] : 1'b1;
            respawn_cnt     <= (&respawn_cnt) ? respawn_cnt : respawn_cnt + 16'd1;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'(NUM_PLAT - 1)) begin
            r_state    <= S_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          overrun <= overrun | w_edge;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_plat_scheduler.sv
// tb_plat_scheduler: directed vectors and corner sequences for plat_scheduler
module tb_plat_scheduler;
  logic         Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, game_reset = 1'b0;
  logic [7:0]   scroll_amt = '0;
  logic [1:0]   difficulty = '0;
  logic [143:0] plat_x, plat_y;
  logic [15:0]  plat_active, respawn_cnt;
  logic         busy, frame_done, overrun;

  int checks = 0, failures = 0, last_resp = 0;
  logic [8:0]  m_x [16];
  logic [8:0]  m_y [16];
  logic [15:0] m_a, m_cnt;
  logic        m_ovr;
  logic [8:0]  m_lfsr;
  logic [8:0]  lfsr_at [16];

  typedef struct {
    logic       gr;
    logic [7:0] s;
    logic [1:0] d;
    logic [8:0] y0;
    logic [8:0] y15;
    logic [15:0] cnt;
  } vec_t;
  vec_t vt [5];

  plat_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_reset(game_reset),
    .scroll_amt(scroll_amt), .difficulty(difficulty),
    .plat_x(plat_x), .plat_y(plat_y), .plat_active(plat_active),
    .busy(busy), .frame_done(frame_done), .respawn_cnt(respawn_cnt), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or posedge Reset)
    if (Reset) m_lfsr <= 9'h1A5;
    else if (game_reset) m_lfsr <= 9'h1A5;
    else m_lfsr <= {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_init;
    for (int i = 0; i < 16; i++) begin
      m_x[i] = 9'(48 + 28 * i);
      m_y[i] = 9'(450 - 30 * i);
    end
    m_a = 16'hFFFF;
    m_cnt = '0;
    m_ovr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [143:0] ex, ey;
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      ex[9*i +: 9] = m_x[i];
      ey[9*i +: 9] = m_y[i];
      if (plat_y[9*i +: 9] >= 9'd480) bad++;
    end
    chk({tag, "_x"}, plat_x, ex);
    chk({tag, "_y"}, plat_y, ey);
    chk({tag, "_active"}, plat_active, m_a);
    chk({tag, "_cnt"}, respawn_cnt, m_cnt);
    chk({tag, "_overrun"}, overrun, m_ovr);
    chk({tag, "_y_range"}, bad, 0);
  endtask

  task automatic pulse_gr;
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    model_init();
  endtask

  task automatic run_frame(input logic [7:0] s, input logic [1:0] d, input bit dbl);
    int nb;
    logic [9:0] ny;
    scroll_amt = s;
    difficulty = d;
    frame_clk = 1'b1;
    for (int n = 0; n < 8 && busy !== 1'b1; n++) tick();
    if (busy !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL frame_start busy=%b required=1", busy);
      frame_clk = 1'b0;
      repeat (4) tick();
      return;
    end
    nb = 0;
    for (int k = 0; k < 16; k++) begin
      lfsr_at[k] = m_lfsr;
      if (busy === 1'b1) nb++;
      if (dbl && k == 0) frame_clk = 1'b0;
      if (dbl && k == 2) frame_clk = 1'b1;
      tick();
    end
    chk("busy_cycles", nb, 16);
    chk("busy_end", busy, 0);
    chk("frame_done_hi", frame_done, 1);
    tick();
    chk("frame_done_lo", frame_done, 0);
    frame_clk = 1'b0;
    repeat (4) tick();
    last_resp = 0;
    for (int k = 0; k < 16; k++) begin
      ny = 10'(m_y[k]) + 10'(s);
      if (ny >= 10'd480) begin
        m_y[k] = 9'(ny - 10'd480);
        m_x[k] = lfsr_at[k];
        m_a[k] = d[1] ? ~lfsr_at[k][0] : 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
        last_resp++;
      end else m_y[k] = ny[8:0];
    end
  endtask

  initial begin
    int nb, inact;
    vt[0] = '{1'b0, 8'd10, 2'd0, 9'd460, 9'd10, 16'd0};
    vt[1] = '{1'b0, 8'd0,  2'd1, 9'd460, 9'd10, 16'd0};
    vt[2] = '{1'b0, 8'd20, 2'd0, 9'd0,   9'd30, 16'd1};
    vt[3] = '{1'b1, 8'd40, 2'd0, 9'd10,  9'd40, 16'd1};
    vt[4] = '{1'b0, 8'd0,  2'd2, 9'd10,  9'd40, 16'd1};

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    model_init();
    check_all("rst");
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_slot0", {plat_x[8:0], plat_y[8:0]}, {9'd48, 9'd450});
    chk("rst_slot15", {plat_x[143:135], plat_y[143:135]}, {9'd468, 9'd0});
    tick();

    for (int v = 0; v < 5; v++) begin
      if (vt[v].gr) pulse_gr();
      run_frame(vt[v].s, vt[v].d, 1'b0);
      check_all($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_y0", v), plat_y[8:0], vt[v].y0);
      chk($sformatf("vec%0d_y15", v), plat_y[143:135], vt[v].y15);
      chk($sformatf("vec%0d_cnt_hand", v), respawn_cnt, vt[v].cnt);
      if (vt[v].gr) chk("respawn_x0", plat_x[8:0], lfsr_at[0]);
    end

    run_frame(8'd30, 2'd0, 1'b1);
    m_ovr = 1'b1;
    check_all("overrun");
    nb = 0;
    repeat (25) begin
      tick();
      if (busy === 1'b1) nb++;
    end
    chk("single_scan", nb, 0);

    frame_clk = 1'b1;
    for (int n = 0; n < 8 && busy !== 1'b1; n++) tick();
    chk("grmid_started", busy, 1);
    repeat (5) tick();
    pulse_gr();
    chk("grmid_busy", busy, 0);
    check_all("grmid");
    frame_clk = 1'b0;
    repeat (4) tick();

    frame_clk = 1'b1;
    tick();
    tick();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    model_init();
    nb = 0;
    repeat (6) begin
      if (busy === 1'b1) nb++;
      tick();
    end
    chk("gr_edge_dropped", nb, 0);
    check_all("gr_edge");
    frame_clk = 1'b0;
    repeat (4) tick();

    pulse_gr();
    inact = 0;
    for (int f = 0; f < 200; f++) begin
      run_frame(8'd255, (f % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
      check_all("hard");
      if (plat_active != 16'hFFFF) inact++;
    end
    chk("hard_some_inactive", inact > 0, 1);

    pulse_gr();
    for (int f = 0; f < 20; f++) begin
      run_frame(8'd255, (f % 2 == 0) ? 2'b00 : 2'b01, 1'b0);
      check_all("easy");
    end
    chk("easy_all_active", plat_active, 16'hFFFF);

    force dut.respawn_cnt = 16'hFFFE;
    tick();
    release dut.respawn_cnt;
    m_cnt = 16'hFFFE;
    chk("preload_cnt", respawn_cnt, 16'hFFFE);
    run_frame(8'd255, 2'b00, 1'b0);
    check_all("sat");
    if (last_resp >= 2) chk("sat_ffff", respawn_cnt, 16'hFFFF);
    run_frame(8'd255, 2'b00, 1'b0);
    check_all("sat2");

    frame_clk = 1'b1;
    for (int n = 0; n < 8 && busy !== 1'b1; n++) tick();
    chk("rstmid_started", busy, 1);
    repeat (4) tick();
    #3 Reset = 1'b1;
    #1;
    model_init();
    check_all("rstmid");
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", frame_done, 0);
    frame_clk = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (3) tick();
    run_frame(8'd10, 2'd0, 1'b0);
    check_all("post_rst");
    chk("post_rst_y0", plat_y[8:0], 9'd460);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
